// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-state sequencer.
// Contents: state encoding, on-screen text codes, default timing/lives
// constants, and the state -> text mapping used by the controller.
package pong_pkg;

   typedef enum logic [1:0] {
      NEWGAME = 2'd0,
      PLAY    = 2'd1,
      NEWBALL = 2'd2,
      OVER    = 2'd3
   } state_t;

   localparam logic [1:0] TXT_NONE    = 2'b00;
   localparam logic [1:0] TXT_START   = 2'b01;
   localparam logic [1:0] TXT_NEWBALL = 2'b10;
   localparam logic [1:0] TXT_OVER    = 2'b11;

   localparam int DEFAULT_LIVES        = 3;
   localparam int DEFAULT_DELAY_FRAMES = 120;

   function automatic logic [1:0] text_for(state_t s);
      case (s)
         NEWGAME: return TXT_START;
         PLAY:    return TXT_NONE;
         NEWBALL: return TXT_NEWBALL;
         default: return TXT_OVER;
      endcase
   endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pixel generator and the game-state sequencer.
//   frame_tick, start, hit, miss : renderer/board -> controller events
//   game_still, ball_reset       : controller -> renderer motion control
//   score_tens/ones, lives       : controller -> renderer score display
//   text_sel, ball_speed         : controller -> renderer text/speed select
// master = renderer side, slave = controller side.
interface pong_game_ctrl_if;
   logic       frame_tick;
   logic       start;
   logic       hit;
   logic       miss;
   logic       game_still;
   logic       ball_reset;
   logic [3:0] score_tens;
   logic [3:0] score_ones;
   logic [1:0] lives;
   logic [1:0] text_sel;
   logic [1:0] ball_speed;

   modport master (
      output frame_tick, start, hit, miss,
      input  game_still, ball_reset, score_tens, score_ones, lives, text_sel, ball_speed
   );

   modport slave (
      input  frame_tick, start, hit, miss,
      output game_still, ball_reset, score_tens, score_ones, lives, text_sel, ball_speed
   );
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter, 00..99, saturating at 99.
//   clk, reset : clock, async active-low reset (clears to 00)
//   clr        : synchronous clear, wins over inc
//   inc        : add one
//   tens, ones : BCD digits (registered)
//   carry      : high in the cycle whose inc will bump the tens digit
module bcd2_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       carry
);

   logic at_max;

   assign at_max = (tens == 4'd9) && (ones == 4'd9);
   assign carry  = inc && !clr && !at_max && (ones == 4'd9);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tens <= 4'd0;
         ones <= 4'd0;
      end else if (clr) begin
         tens <= 4'd0;
         ones <= 4'd0;
      end else if (inc && !at_max) begin
         if (ones == 4'd9) begin
            ones <= 4'd0;
            tens <= tens + 4'd1;
         end else begin
            ones <= ones + 4'd1;
         end
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-state sequencer for the VGA pong datapath.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : pong_game_ctrl_if.slave (events in, freeze/score/lives/text out)
// Optional macro SCORE_SPEEDUP_EN: ball_speed steps up with every tens-digit
// increment (saturating at 3); when undefined ball_speed is tied to 0.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   NEWGAME | start screen, frozen, waiting for a start rise
//   PLAY    | ball live; hit scores, miss costs a life
//   NEWBALL | frozen for DELAY_FRAMES ticks, then re-centre and play
//   OVER    | frozen for DELAY_FRAMES ticks showing final score, then NEWGAME
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int LIVES        = DEFAULT_LIVES,
   parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES
) (
   input  logic             clk,
   input  logic             reset,
   pong_game_ctrl_if.slave  bus
);

   localparam logic [7:0] TIMER_LOAD = 8'(DELAY_FRAMES - 1);
   localparam logic [1:0] LIVES_INIT = 2'(LIVES);

   state_t     state, state_nxt;
   logic [7:0] timer, timer_nxt;
   logic [1:0] lives_q, lives_nxt;
   logic       start_d;
   logic       start_rise;
   logic       ball_reset_q, ball_reset_nxt;
   logic       game_still_q;
   logic [1:0] text_sel_q;
   logic       score_clr, score_inc, tens_carry;
   logic [3:0] tens, ones;

   // start_d resets to 1 so a button held through reset is not a rise
   assign start_rise = bus.start && !start_d;

   always_comb begin
      state_nxt      = state;
      timer_nxt      = timer;
      lives_nxt      = lives_q;
      ball_reset_nxt = 1'b0;
      score_clr      = 1'b0;
      score_inc      = 1'b0;
      case (state)
         NEWGAME: begin
            if (start_rise) begin
               state_nxt      = PLAY;
               lives_nxt      = LIVES_INIT;
               score_clr      = 1'b1;
               ball_reset_nxt = 1'b1;
            end
         end
         PLAY: begin
            // miss has priority; a simultaneous hit is dropped
            if (bus.miss) begin
               lives_nxt = lives_q - 2'd1;
               timer_nxt = TIMER_LOAD;
               state_nxt = (lives_q == 2'd1) ? OVER : NEWBALL;
            end else if (bus.hit) begin
               score_inc = 1'b1;
            end
         end
         NEWBALL, OVER: begin
            if (bus.frame_tick) begin
               if (timer == 8'd0) begin
                  state_nxt      = (state == NEWBALL) ? PLAY : NEWGAME;
                  ball_reset_nxt = (state == NEWBALL);
               end else begin
                  timer_nxt = timer - 8'd1;
               end
            end
         end
         default: state_nxt = NEWGAME;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= NEWGAME;
         timer        <= 8'd0;
         lives_q      <= LIVES_INIT;
         start_d      <= 1'b1;
         ball_reset_q <= 1'b0;
         game_still_q <= 1'b1;
         text_sel_q   <= TXT_START;
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         lives_q      <= lives_nxt;
         start_d      <= bus.start;
         ball_reset_q <= ball_reset_nxt;
         game_still_q <= (state_nxt != PLAY);
         text_sel_q   <= text_for(state_nxt);
      end
   end

   bcd2_counter u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (score_clr),
      .inc   (score_inc),
      .tens  (tens),
      .ones  (ones),
      .carry (tens_carry)
   );

`ifdef SCORE_SPEEDUP_EN
   logic [1:0] speed_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         speed_q <= 2'd0;
      end else if (score_clr) begin
         speed_q <= 2'd0;
      end else if (tens_carry && (speed_q != 2'd3)) begin
         speed_q <= speed_q + 2'd1;
      end
   end

   assign bus.ball_speed = speed_q;
`else
   logic speed_unused;

   assign speed_unused   = tens_carry;
   assign bus.ball_speed = 2'd0;
`endif

   assign bus.game_still = game_still_q;
   assign bus.ball_reset = ball_reset_q;
   assign bus.score_tens = tens;
   assign bus.score_ones = ones;
   assign bus.lives      = lives_q;
   assign bus.text_sel   = text_sel_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl (LIVES=3, DELAY_FRAMES=4) with a
// behavioural game model: score as an integer, a ticks-remaining count.
module tb_pong_game_ctrl;

   localparam int LIVES = 3;
   localparam int DELAY = 4;

   localparam int M_NEWGAME = 0;
   localparam int M_PLAY    = 1;
   localparam int M_NEWBALL = 2;
   localparam int M_OVER    = 3;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pong_game_ctrl_if bus ();

   pong_game_ctrl #(.LIVES(LIVES), .DELAY_FRAMES(DELAY)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int m_mode, m_score, m_lives, m_left, m_speed;
   bit m_br, m_start_prev;
   bit cur_start;

   function automatic void model_reset();
      m_mode       = M_NEWGAME;
      m_score      = 0;
      m_lives      = LIVES;
      m_left       = 0;
      m_speed      = 0;
      m_br         = 1'b0;
      m_start_prev = 1'b1;
   endfunction

   function automatic void model_step(bit fr, bit st, bit h, bit m);
      bit rise;
      rise = st && !m_start_prev;
      m_start_prev = st;
      m_br = 1'b0;
      case (m_mode)
         M_NEWGAME: if (rise) begin
            m_mode  = M_PLAY;
            m_score = 0;
            m_lives = LIVES;
            m_speed = 0;
            m_br    = 1'b1;
         end
         M_PLAY: begin
            if (m) begin
               m_lives = m_lives - 1;
               m_mode  = (m_lives == 0) ? M_OVER : M_NEWBALL;
               m_left  = DELAY;
            end else if (h && m_score < 99) begin
`ifdef SCORE_SPEEDUP_EN
               if (m_score % 10 == 9 && m_speed < 3) m_speed = m_speed + 1;
`endif
               m_score = m_score + 1;
            end
         end
         default: if (fr) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_br   = (m_mode == M_NEWBALL);
               m_mode = (m_mode == M_NEWBALL) ? M_PLAY : M_NEWGAME;
            end
         end
      endcase
   endfunction

   function automatic logic [1:0] exp_text();
      case (m_mode)
         M_NEWGAME: return 2'b01;
         M_PLAY:    return 2'b00;
         M_NEWBALL: return 2'b10;
         default:   return 2'b11;
      endcase
   endfunction

   function automatic logic [15:0] exp_vec();
      return {m_mode != M_PLAY, m_br, 4'(m_score / 10), 4'(m_score % 10),
              2'(m_lives), exp_text(), 2'(m_speed)};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {bus.game_still, bus.ball_reset, bus.score_tens, bus.score_ones,
              bus.lives, bus.text_sel, bus.ball_speed};
   endfunction

   // one clock: drive at negedge, model the posedge, leave time at posedge+1
   task automatic step(input bit fr, input bit h, input bit m);
      @(negedge clk);
      bus.frame_tick = fr;
      bus.start      = cur_start;
      bus.hit        = h;
      bus.miss       = m;
      @(posedge clk);
      model_step(fr, cur_start, h, m);
      #1;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      cur_start      = 1'b1;
      bus.start      = 1'b1;
      bus.frame_tick = 1'b0;
      bus.hit        = 1'b0;
      bus.miss       = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (obs_vec() !== 16'b1_0_0000_0000_11_01_00) begin
         n_fail++;
         $display("FAIL reset_values: got %b expected %b", obs_vec(), 16'b1_0_0000_0000_11_01_00);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
         n_tests++;
         if (bus.text_sel !== 2'b01 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL held_start: got %b expected %b", obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_start();
      cur_start = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      cur_start = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (bus.game_still !== 1'b0 || bus.ball_reset !== 1'b1 ||
          {bus.score_tens, bus.score_ones} !== 8'h00 || bus.lives !== 2'd3) begin
         n_fail++;
         $display("FAIL start_rise: got still=%b br=%b score=%h%h lives=%0d expected 0 1 00 3",
                  bus.game_still, bus.ball_reset, bus.score_tens, bus.score_ones, bus.lives);
      end
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (bus.ball_reset !== 1'b0 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL ball_reset_width: got %b expected %b", obs_vec(), exp_vec());
      end
   endtask

   task automatic hits(input int n);
      for (int i = 0; i < n; i++) begin
         gap($urandom_range(0, 2));
         step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end
   endtask

   task automatic test_score();
      hits(12);
      n_tests++;
      if ({bus.score_tens, bus.score_ones} !== 8'h12 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL score_12: got %h%h expected 12", bus.score_tens, bus.score_ones);
      end
      hits(90);
      n_tests++;
      if ({bus.score_tens, bus.score_ones} !== 8'h99 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL score_99: got %h%h expected 99", bus.score_tens, bus.score_ones);
      end
      hits(1);
      n_tests++;
      if ({bus.score_tens, bus.score_ones} !== 8'h99) begin
         n_fail++;
         $display("FAIL score_sat: got %h%h expected 99", bus.score_tens, bus.score_ones);
      end
      n_tests++;
`ifdef SCORE_SPEEDUP_EN
      if (bus.ball_speed !== 2'd3) begin
         n_fail++;
         $display("FAIL speed_sat: got %0d expected 3", bus.ball_speed);
      end
`else
      if (bus.ball_speed !== 2'd0) begin
         n_fail++;
         $display("FAIL speed_off: got %0d expected 0", bus.ball_speed);
      end
`endif
   endtask

   // waits out a NEWBALL/OVER dwell with random gaps, checking every tick
   task automatic test_dwell(input string name, input logic [1:0] txt, input bit noise);
      for (int t = 1; t <= DELAY; t++) begin
         gap($urandom_range(0, 3));
         step(1'b1, noise && $urandom_range(0, 1) == 1, noise && $urandom_range(0, 1) == 1);
         n_tests++;
         if (t < DELAY && (bus.text_sel !== txt || obs_vec() !== exp_vec())) begin
            n_fail++;
            $display("FAIL %s_tick%0d: got %b expected %b", name, t, obs_vec(), exp_vec());
         end else if (t == DELAY && obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL %s_expiry: got %b expected %b", name, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_hit_miss_same();
      step(1'b1, 1'b1, 1'b1);
      n_tests++;
      if ({bus.score_tens, bus.score_ones} !== 8'h99 || bus.lives !== 2'd2 ||
          bus.text_sel !== 2'b10 || bus.game_still !== 1'b1) begin
         n_fail++;
         $display("FAIL hit_miss: got score=%h%h lives=%0d text=%b expected 99 2 10",
                  bus.score_tens, bus.score_ones, bus.lives, bus.text_sel);
      end
      test_dwell("newball", 2'b10, 1'b0);
      n_tests++;
      if (bus.game_still !== 1'b0 || bus.ball_reset !== 1'b1) begin
         n_fail++;
         $display("FAIL newball_exit: got still=%b br=%b expected 0 1", bus.game_still, bus.ball_reset);
      end
   endtask

   task automatic test_game_over();
      gap(2);
      step(1'b0, 1'b0, 1'b1);
      test_dwell("newball2", 2'b10, 1'b0);
      gap(1);
      step(1'b0, 1'b1, 1'b1);
      n_tests++;
      if (bus.lives !== 2'd0 || bus.text_sel !== 2'b11 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL enter_over: got lives=%0d text=%b expected 0 11", bus.lives, bus.text_sel);
      end
      test_dwell("over", 2'b11, 1'b1);
      n_tests++;
      if (bus.text_sel !== 2'b01 || {bus.score_tens, bus.score_ones} !== 8'h99 || bus.lives !== 2'd0) begin
         n_fail++;
         $display("FAIL over_exit: got text=%b score=%h%h lives=%0d expected 01 99 0",
                  bus.text_sel, bus.score_tens, bus.score_ones, bus.lives);
      end
      for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'b1, i[0]);
      n_tests++;
      if ({bus.score_tens, bus.score_ones} !== 8'h99 || bus.lives !== 2'd0 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL newgame_ignore: got %b expected %b", obs_vec(), exp_vec());
      end
      cur_start = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      cur_start = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({bus.score_tens, bus.score_ones} !== 8'h00 || bus.lives !== 2'd3 || bus.ball_reset !== 1'b1) begin
         n_fail++;
         $display("FAIL restart: got score=%h%h lives=%0d br=%b expected 00 3 1",
                  bus.score_tens, bus.score_ones, bus.lives, bus.ball_reset);
      end
   endtask

   task automatic test_async_reset();
      hits(5);
      step(1'b0, 1'b0, 1'b1);
      gap(1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (bus.text_sel !== 2'b10 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL pre_reset: got %b expected %b", obs_vec(), exp_vec());
      end
      #2 reset = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if (bus.game_still !== 1'b1 || {bus.score_tens, bus.score_ones} !== 8'h00 ||
          bus.lives !== 2'd3 || bus.ball_reset !== 1'b0 || bus.text_sel !== 2'b01) begin
         n_fail++;
         $display("FAIL async_reset: got %b expected %b", obs_vec(), exp_vec());
      end
      @(posedge clk);
      #1 reset = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL post_reset: got %b expected %b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) cur_start = ~cur_start;
         step(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %b expected %b", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_score();
      test_hit_miss_same();
      test_game_over();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
